// File: rtl/onchip_ram_arbiter.sv
// Round-robin two-master arbiter and linear burst sequencer for the single-port on-chip RAM.
// Optional address bounds check enabled by defining ONCHIP_ARB_BOUNDS_CHECK_EN.
module onchip_ram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 38400,
  parameter int BURST_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [BURST_W-1:0]    m1_burstcount,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  err_oob
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BURST_RD, BURST_WR} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                lastGrant_q;
  logic [BURST_W-1:0]  beatCnt_q;
  logic [ADDR_W-1:0]   burstAddr_q;
  logic                rdPending_q;
  logic                rdOwner_q;

  logic                req0, req1, winner, winWrite, ownWrite;
  logic [ADDR_W-1:0]   winAddr;
  logic [BURST_W-1:0]  winCount;
  logic [BE_W-1:0]     ownBe;
  logic [DATA_W-1:0]   ownData;
  logic                issue, issueWr, issueMaster, oob;
  logic [ADDR_W-1:0]   issueAddr;
  logic [BE_W-1:0]     issueBe;
  logic [DATA_W-1:0]   issueData;
  logic                wait0, wait1;
  logic [DATA_W-1:0]   rdData;

  // A zero burstcount means one word; anything beyond 16 is clamped to 16.
  function automatic logic [BURST_W-1:0] clampCount(input logic [BURST_W-1:0] bc);
    if (bc == '0) return BURST_W'(1);
    if (bc > BURST_W'(16)) return BURST_W'(16);
    return bc;
  endfunction

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign winner   = (req0 & req1) ? ~lastGrant_q : req1;
  assign winWrite = winner ? m1_write : m0_write;
  assign winAddr  = winner ? m1_address : m0_address;
  assign winCount = clampCount(winner ? m1_burstcount : m0_burstcount);
  assign ownWrite = owner_q ? m1_write : m0_write;
  assign ownBe    = (state_q == IDLE ? winner : owner_q) ? m1_byteenable : m0_byteenable;
  assign ownData  = (state_q == IDLE ? winner : owner_q) ? m1_writedata : m0_writedata;

  always_comb begin
    issue       = 1'b0;
    issueWr     = 1'b0;
    issueMaster = owner_q;
    issueAddr   = burstAddr_q;
    issueBe     = '1;
    issueData   = '0;
    wait0       = 1'b1;
    wait1       = 1'b1;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            issue       = 1'b1;
            issueMaster = winner;
            issueWr     = winWrite;
            issueAddr   = winAddr;
            issueBe     = winWrite ? ownBe : '1;
            issueData   = ownData;
            if (winner) wait1 = 1'b0;
            else        wait0 = 1'b0;
          end
        end
        BURST_RD: issue = 1'b1;
        BURST_WR: begin
          // Only write beats are accepted; the owner stalls on anything else.
          if (ownWrite) begin
            issue     = 1'b1;
            issueWr   = 1'b1;
            issueBe   = ownBe;
            issueData = ownData;
            if (owner_q) wait1 = 1'b0;
            else         wait0 = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic rdOob_q;

  assign oob = issue && ({1'b0, issueAddr} >= DEPTH_L);

  // Suppressed reads still return a beat, with a recognisable poison word.
  always_ff @(posedge clk) begin
    if (reset) rdOob_q <= 1'b0;
    else       rdOob_q <= oob & ~issueWr;
  end

  assign rdData = rdOob_q ? DATA_W'(32'hDEADBEEF) : mem_readdata;
`else
  assign oob    = 1'b0;
  assign rdData = mem_readdata;
`endif

  assign mem_address      = issueAddr;
  assign mem_chipselect   = issue & ~oob;
  assign mem_write        = issueWr & ~oob;
  assign mem_byteenable   = issueBe;
  assign mem_writedata    = issueData;
  assign err_oob          = oob;
  assign m0_waitrequest   = wait0;
  assign m1_waitrequest   = wait1;
  assign m0_readdata      = rdData;
  assign m1_readdata      = rdData;
  assign m0_readdatavalid = rdPending_q & ~rdOwner_q & ~reset;
  assign m1_readdatavalid = rdPending_q &  rdOwner_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      beatCnt_q   <= '0;
      burstAddr_q <= '0;
      rdPending_q <= 1'b0;
      rdOwner_q   <= 1'b0;
    end else begin
      rdPending_q <= issue & ~issueWr;
      rdOwner_q   <= issueMaster;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            lastGrant_q <= winner;
            owner_q     <= winner;
            if (winCount != BURST_W'(1)) begin
              state_q     <= winWrite ? BURST_WR : BURST_RD;
              beatCnt_q   <= winCount - BURST_W'(1);
              burstAddr_q <= winAddr + ADDR_W'(1);
            end
          end
        end
        BURST_RD, BURST_WR: begin
          if (issue) begin
            burstAddr_q <= burstAddr_q + ADDR_W'(1);
            beatCnt_q   <= beatCnt_q - BURST_W'(1);
            if (beatCnt_q == BURST_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = 4'hF, m1_byteenable = 4'hF;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [4:0]  m0_burstcount = 5'd1, m1_burstcount = 5'd1;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [15:0] mem_address;
  logic        mem_chipselect, mem_write, err_oob;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] ram [0:65535];
  logic [15:0] ramRaddr = '0;
  logic        initRam = 1'b1;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  onchip_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .err_oob(err_oob)
  );

  // Input-registered RAM, preloaded with {A5A5, address} so read data identifies its source word.
  always @(posedge clk) begin
    if (initRam) begin
      for (int i = 0; i < 65536; i++) ram[i] <= {16'hA5A5, i[15:0]};
    end else if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ramRaddr <= mem_address;
    end
  end
  assign mem_readdata = ram[ramRaddr];

  // One cycle: drive inputs just after the rising edge, then settle at the falling edge.
  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0, input logic [15:0] a0,
                               input logic [31:0] d0, input logic [4:0] b0,
                               input logic r1, input logic [15:0] a1, input logic [4:0] b1);
    @(posedge clk);
    #1;
    reset         = rst;
    m0_read       = r0;
    m0_write      = w0;
    m0_address    = a0;
    m0_writedata  = d0;
    m0_burstcount = b0;
    m1_read       = r1;
    m1_address    = a1;
    m1_burstcount = b1;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with both masters requesting: nothing may be granted or issued.
    applyStimulus(1, 1, 0, 16'h0010, 0, 1, 1, 16'h0020, 1);
    initRam = 1'b0;
    checkOutput("rst_m0_wait", m0_waitrequest, 1);
    checkOutput("rst_m1_wait", m1_waitrequest, 1);
    checkOutput("rst_cs", mem_chipselect, 0);
    checkOutput("rst_we", mem_write, 0);
    checkOutput("rst_err", err_oob, 0);

    // Single write then single read-back.
    applyStimulus(0, 0, 1, 16'h0010, 32'h12345678, 1, 0, 0, 1);
    checkOutput("wr_wait", m0_waitrequest, 0);
    checkOutput("wr_cs", mem_chipselect, 1);
    checkOutput("wr_we", mem_write, 1);
    checkOutput("wr_addr", mem_address, 32'h0010);
    checkOutput("wr_data", mem_writedata, 32'h12345678);
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 0, 0, 1);
    checkOutput("rd_wait", m0_waitrequest, 0);
    checkOutput("rd_we", mem_write, 0);
    checkOutput("rd_be", mem_byteenable, 32'hF);
    checkOutput("rd_addr", mem_address, 32'h0010);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rd_valid", m0_readdatavalid, 1);
    checkOutput("rd_data", m0_readdata, 32'h12345678);
    checkOutput("rd_m1valid", m1_readdatavalid, 0);

    // Fresh reset, then four tie cycles: m0, m1, m0, m1.
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 1, 16'h0020, 1);
    checkOutput("tie1_m0wait", m0_waitrequest, 0);
    checkOutput("tie1_m1wait", m1_waitrequest, 1);
    checkOutput("tie1_addr", mem_address, 32'h0010);
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 1, 16'h0020, 1);
    checkOutput("tie2_m0wait", m0_waitrequest, 1);
    checkOutput("tie2_m1wait", m1_waitrequest, 0);
    checkOutput("tie2_addr", mem_address, 32'h0020);
    checkOutput("tie2_m0valid", m0_readdatavalid, 1);
    checkOutput("tie2_m0data", m0_readdata, 32'h12345678);
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 1, 16'h0020, 1);
    checkOutput("tie3_m0wait", m0_waitrequest, 0);
    checkOutput("tie3_m1valid", m1_readdatavalid, 1);
    checkOutput("tie3_m1data", m1_readdata, 32'hA5A50020);
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 1, 16'h0020, 1);
    checkOutput("tie4_m1wait", m1_waitrequest, 0);
    checkOutput("tie4_m0valid", m0_readdatavalid, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("tie5_m1valid", m1_readdatavalid, 1);

    // m1 read burst of 8 at 0x0100 while m0 keeps requesting.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0100, 5'd8);
    checkOutput("bu0_m1wait", m1_waitrequest, 0);
    checkOutput("bu0_addr", mem_address, 32'h0100);
    for (int k = 1; k < 8; k++) begin
      applyStimulus(0, 1, 0, 16'h0010, 0, 1, 0, 0, 1);
      checkOutput($sformatf("bu%0d_m0wait", k), m0_waitrequest, 1);
      checkOutput($sformatf("bu%0d_m1wait", k), m1_waitrequest, 1);
      checkOutput($sformatf("bu%0d_addr", k), mem_address, 32'h0100 + k);
      checkOutput($sformatf("bu%0d_m1valid", k), m1_readdatavalid, 1);
      checkOutput($sformatf("bu%0d_m1data", k), m1_readdata, 32'hA5A50100 + k - 1);
    end
    applyStimulus(0, 1, 0, 16'h0010, 0, 1, 0, 0, 1);
    checkOutput("bu8_m0wait", m0_waitrequest, 0);
    checkOutput("bu8_addr", mem_address, 32'h0010);
    checkOutput("bu8_m1valid", m1_readdatavalid, 1);
    checkOutput("bu8_m1data", m1_readdata, 32'hA5A50107);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("bu9_m1valid", m1_readdatavalid, 0);
    checkOutput("bu9_m0valid", m0_readdatavalid, 1);

    // m0 write burst of 4 at 0xFFFE, wrapping, with a two-cycle gap after beat 1.
    applyStimulus(0, 0, 1, 16'hFFFE, 32'h11111111, 5'd4, 0, 0, 1);
    checkOutput("wb0_wait", m0_waitrequest, 0);
    checkOutput("wb0_we", mem_write, 1);
    checkOutput("wb0_addr", mem_address, 32'hFFFE);
    applyStimulus(0, 0, 1, 16'h0000, 32'h22222222, 5'd4, 0, 0, 1);
    checkOutput("wb1_wait", m0_waitrequest, 0);
    checkOutput("wb1_we", mem_write, 1);
    checkOutput("wb1_addr", mem_address, 32'hFFFF);
    checkOutput("wb1_data", mem_writedata, 32'h22222222);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0020, 1);
    checkOutput("wbg1_we", mem_write, 0);
    checkOutput("wbg1_cs", mem_chipselect, 0);
    checkOutput("wbg1_m1wait", m1_waitrequest, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0020, 1);
    checkOutput("wbg2_we", mem_write, 0);
    checkOutput("wbg2_cs", mem_chipselect, 0);
    applyStimulus(0, 0, 1, 16'h0000, 32'h33333333, 1, 1, 16'h0020, 1);
    checkOutput("wb2_wait", m0_waitrequest, 0);
    checkOutput("wb2_we", mem_write, 1);
    checkOutput("wb2_addr", mem_address, 32'h0000);
    checkOutput("wb2_m1wait", m1_waitrequest, 1);
    applyStimulus(0, 0, 1, 16'h0000, 32'h44444444, 1, 1, 16'h0020, 1);
    checkOutput("wb3_we", mem_write, 1);
    checkOutput("wb3_addr", mem_address, 32'h0001);
    checkOutput("wb3_data", mem_writedata, 32'h44444444);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0020, 1);
    checkOutput("wb4_m1wait", m1_waitrequest, 0);
    checkOutput("wb4_addr", mem_address, 32'h0020);
    checkOutput("wb4_we", mem_write, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 1, 0, 0, 1);
    checkOutput("wb5_m0wait", m0_waitrequest, 0);
    checkOutput("wb5_m1valid", m1_readdatavalid, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("wb6_m0valid", m0_readdatavalid, 1);
    checkOutput("wb6_m0data", m0_readdata, 32'h33333333);

    // Reset lands on beat 3 of an 8-beat read burst.
    applyStimulus(0, 1, 0, 16'h0200, 0, 5'd8, 0, 0, 1);
    checkOutput("rb0_addr", mem_address, 32'h0200);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rb1_addr", mem_address, 32'h0201);
    checkOutput("rb1_m0valid", m0_readdatavalid, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rb2_addr", mem_address, 32'h0202);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rb3_cs", mem_chipselect, 0);
    checkOutput("rb3_m0wait", m0_waitrequest, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rb4_m0valid", m0_readdatavalid, 0);
    checkOutput("rb4_cs", mem_chipselect, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 16'h0020, 1);
    checkOutput("rb5_m1wait", m1_waitrequest, 0);
    checkOutput("rb5_addr", mem_address, 32'h0020);
    checkOutput("rb5_cs", mem_chipselect, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("rb6_m1valid", m1_readdatavalid, 1);
    checkOutput("rb6_m1data", m1_readdata, 32'hA5A50020);
    checkOutput("rb6_m0valid", m0_readdatavalid, 0);

    // Read at address 38400, just past the RAM.
    applyStimulus(0, 1, 0, 16'd38400, 0, 1, 0, 0, 1);
    checkOutput("oob0_m0wait", m0_waitrequest, 0);
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    checkOutput("oob0_err", err_oob, 1);
    checkOutput("oob0_cs", mem_chipselect, 0);
    applyStimulus(0, 1, 0, 16'd38399, 0, 1, 0, 0, 1);
    checkOutput("oob1_err", err_oob, 0);
    checkOutput("oob1_cs", mem_chipselect, 1);
    checkOutput("oob1_m0valid", m0_readdatavalid, 1);
    checkOutput("oob1_m0data", m0_readdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("oob2_m0valid", m0_readdatavalid, 1);
    checkOutput("oob2_m0data", m0_readdata, 32'hA5A595FF);
`else
    checkOutput("oob0_err", err_oob, 0);
    checkOutput("oob0_cs", mem_chipselect, 1);
    checkOutput("oob0_addr", mem_address, 32'h9600);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("oob1_m0valid", m0_readdatavalid, 1);
    checkOutput("oob1_m0data", m0_readdata, 32'hA5A59600);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
